// File: rtl/pwm_cmp_pkg.sv
// Shared types and constants for the PWM compare-value conditioning path.
// Used by boxcar_accum and pwm_compare_ctrl.
package pwm_cmp_pkg;

    localparam int SAMPLE_W           = 10;
    localparam int CHANNEL_W          = 4;
    localparam int AVG_LOG2_MAX       = 6;
    localparam int WDT_CYCLES_DEFAULT = 5_000_000;

    typedef logic [SAMPLE_W-1:0]  sample_t;
    typedef logic [CHANNEL_W-1:0] channel_t;

    typedef enum logic {
        WDT_RUN   = 1'b0,
        WDT_STALE = 1'b1
    } wdt_state_t;

endpackage

// File: rtl/boxcar_accum.sv
// Box-car averager: sums 2^AVG_LOG2 valid samples and emits their truncated
// mean as a single-cycle strobe in the same cycle as the final sample.
module boxcar_accum
    import pwm_cmp_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                out_valid,
    output logic [SAMPLE_W-1:0] out_data
);

    // One extra bit per doubling of the sample count, so the sum cannot wrap.
    localparam int ACC_W = SAMPLE_W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             last;

    // NOTE: every signal assigned in always_comb gets a value on every path,
    // otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        sum       = acc + ACC_W'(in_data);
        last      = (cnt == CNT_LAST);
        out_valid = in_valid && last;
        out_data  = SAMPLE_W'(sum >> AVG_LOG2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (in_valid) begin
            if (last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_compare_ctrl.sv
// Averages one ADC channel and commits the result to the PWM compare value only
// at a period boundary. Define PWM_CMP_WDT_EN to add the sample-starvation watchdog.
module pwm_compare_ctrl
    import pwm_cmp_pkg::*;
#(
    parameter int CHANNEL    = 0,
    parameter int AVG_LOG2   = 2,
    parameter int WDT_CYCLES = WDT_CYCLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 new_sample,
    input  logic [SAMPLE_W-1:0]  sample,
    input  logic [CHANNEL_W-1:0] sample_channel,
    input  logic                 period_start,
    output logic [SAMPLE_W-1:0]  compare,
    output logic                 update,
    output logic                 stale
);

    if (AVG_LOG2 < 0 || AVG_LOG2 > AVG_LOG2_MAX) begin : g_bad_avg_log2
        $error("pwm_compare_ctrl: AVG_LOG2 must be 0..%0d", AVG_LOG2_MAX);
    end
    if (WDT_CYCLES < 2) begin : g_bad_wdt_cycles
        $error("pwm_compare_ctrl: WDT_CYCLES must be at least 2");
    end

    logic    accepted;
    logic    avg_valid;
    sample_t avg_data;
    logic    pend;
    sample_t pend_val;
    logic    wdt_fire;

    assign accepted = new_sample && (sample_channel == CHANNEL_W'(CHANNEL));

    boxcar_accum #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_boxcar (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accepted),
        .in_data   (sample),
        .out_valid (avg_valid),
        .out_data  (avg_data)
    );

`ifdef PWM_CMP_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LAST    = WDT_W'(WDT_CYCLES - 1);
    localparam logic [WDT_W-1:0] WDT_FIRE_AT = WDT_W'(WDT_CYCLES - 2);

    logic [WDT_W-1:0] wdt_cnt;
    wdt_state_t       wdt_state;

    // Fires once, on the edge where the idle count reaches WDT_CYCLES-1;
    // saturation then holds it off until a sample restarts the count.
    assign wdt_fire = !accepted && (wdt_cnt == WDT_FIRE_AT);
    assign stale    = (wdt_state == WDT_STALE);

    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt   <= '0;
            wdt_state <= WDT_RUN;
        end else begin
            if (accepted) begin
                wdt_cnt <= '0;
            end else if (wdt_cnt != WDT_LAST) begin
                wdt_cnt <= wdt_cnt + WDT_W'(1);
            end

            if (avg_valid) begin
                wdt_state <= WDT_RUN;
            end else if (wdt_fire) begin
                wdt_state <= WDT_STALE;
            end
        end
    end
`else
    assign wdt_fire = 1'b0;
    assign stale    = 1'b0;
`endif

    // NOTE: non-blocking assignments make every read below see the value from
    // before the edge, and a later assignment in this block overrides an
    // earlier one. That is exactly how an average landing on a period_start
    // edge commits the old pend_val yet leaves the new one pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            compare  <= '0;
            update   <= 1'b0;
            pend     <= 1'b0;
            pend_val <= '0;
        end else begin
            update <= 1'b0;

            if (period_start && pend) begin
                compare <= pend_val;
                update  <= 1'b1;
                pend    <= 1'b0;
            end

            if (avg_valid) begin
                pend_val <= avg_data;
                pend     <= 1'b1;
            end else if (wdt_fire) begin
                pend_val <= '0;
                pend     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_compare_ctrl.sv
// Self-checking bench for pwm_compare_ctrl: vector table plus corner sequences,
// with a scoreboard of expected commits checked on every update pulse.
module tb_pwm_compare_ctrl;
    import pwm_cmp_pkg::*;

    localparam int AVG_LOG2   = 2;
    localparam int N_AVG      = 1 << AVG_LOG2;
    localparam int WDT_CYCLES = 1000;

    logic        clk            = 1'b0;
    logic        rst            = 1'b1;
    logic        new_sample     = 1'b0;
    logic [9:0]  sample         = '0;
    logic [3:0]  sample_channel = '0;
    logic        period_start   = 1'b0;
    logic [9:0]  compare;
    logic        update;
    logic        stale;

    always #10 clk = ~clk;

    pwm_compare_ctrl #(
        .CHANNEL    (0),
        .AVG_LOG2   (AVG_LOG2),
        .WDT_CYCLES (WDT_CYCLES)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .new_sample     (new_sample),
        .sample         (sample),
        .sample_channel (sample_channel),
        .period_start   (period_start),
        .compare        (compare),
        .update         (update),
        .stale          (stale)
    );

    typedef struct {
        logic [3:0][9:0] s;
        bit              interleave;
        logic [9:0]      exp;
    } vec_t;

    int         n_checks  = 0;
    int         n_fail    = 0;
    int         n_updates = 0;
    logic [9:0] exp_q[$];

    // Behavioural reference of the pending/commit path.
    int         m_acc   = 0;
    int         m_cnt   = 0;
    logic [9:0] m_val   = '0;
    bit         m_pend  = 1'b0;
    int         m_wdt   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int c, input int d,
                                input bit il, input int e);
        vec_t v;
        v.s[0] = 10'(a); v.s[1] = 10'(b); v.s[2] = 10'(c); v.s[3] = 10'(d);
        v.interleave = il;
        v.exp = 10'(e);
        return v;
    endfunction

    task automatic model_reset();
        m_acc = 0; m_cnt = 0; m_val = '0; m_pend = 1'b0; m_wdt = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input bit ns, input logic [9:0] s, input logic [3:0] ch, input bit ps);
        bit acc_ok;
        acc_ok = ns && (ch == 4'd0);
        if (ps && m_pend) begin
            exp_q.push_back(m_val);
            m_pend = 1'b0;
        end
        if (acc_ok) begin
            if (m_cnt == N_AVG - 1) begin
                m_val  = 10'((m_acc + int'(s)) >> AVG_LOG2);
                m_pend = 1'b1;
                m_acc  = 0;
                m_cnt  = 0;
            end else begin
                m_acc += int'(s);
                m_cnt++;
            end
        end
`ifdef PWM_CMP_WDT_EN
        if (acc_ok) begin
            m_wdt = 0;
        end else if (m_wdt != WDT_CYCLES - 1) begin
            m_wdt++;
            if (m_wdt == WDT_CYCLES - 1) begin
                m_val  = '0;
                m_pend = 1'b1;
            end
        end
`endif
    endtask

    // One clock cycle: drive at negedge, outputs are checked 1 ns after posedge.
    task automatic drive_cycle(input bit ns, input logic [9:0] s, input logic [3:0] ch, input bit ps);
        @(negedge clk);
        new_sample     = ns;
        sample         = s;
        sample_channel = ch;
        period_start   = ps;
        if (!rst) model_step(ns, s, ch, ps);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_cycle(1'b0, 10'd0, 4'd0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst          = 1'b1;
        new_sample   = 1'b0;
        period_start = 1'b0;
        model_reset();
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        new_sample = 1'b0;
        period_start = 1'b0;
        model_step(1'b0, 10'd0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_avg(input logic [3:0][9:0] s, input bit interleave);
        for (int i = 0; i < N_AVG; i++) begin
            drive_cycle(1'b1, s[i], 4'd0, 1'b0);
            if (interleave && i < N_AVG - 1) drive_cycle(1'b1, 10'd1023, 4'd3, 1'b0);
        end
    endtask

    task automatic commit_and_check(input string name, input logic [9:0] exp);
        drive_cycle(1'b0, 10'd0, 4'd0, 1'b1);
        check({name, "_compare"}, compare, exp);
        check({name, "_update"}, update, 1);
        drive_cycle(1'b0, 10'd0, 4'd0, 1'b0);
        check({name, "_update_drop"}, update, 0);
    endtask

    // Scoreboard: every update pulse must match the oldest expected commit.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!rst && update === 1'b1) begin
                n_updates++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_update: got compare %0d, want no update", compare);
                end else begin
                    check("scoreboard_compare", compare, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish, want finish within 1 ms");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        vec_t vecs[6];
        int   u0;
        logic [3:0][9:0] s;

        vecs[0] = mk(100, 101, 102, 103, 1'b1, 101);
        vecs[1] = mk(1023, 1023, 1023, 1023, 1'b0, 1023);
        vecs[2] = mk(1, 1, 1, 2, 1'b1, 1);
        vecs[3] = mk(3, 3, 3, 2, 1'b0, 2);
        vecs[4] = mk(0, 0, 0, 0, 1'b0, 0);
        vecs[5] = mk(100, 200, 300, 401, 1'b1, 250);

        // Reset values.
        do_reset(3);
        check("reset_compare", compare, 0);
        check("reset_update", update, 0);
        check("reset_stale", stale, 0);
        release_reset();

        // Reset after two of four samples discards the partial sum.
        drive_cycle(1'b1, 10'd900, 4'd0, 1'b0);
        drive_cycle(1'b1, 10'd900, 4'd0, 1'b0);
        do_reset(2);
        check("midreset_compare", compare, 0);
        check("midreset_update", update, 0);
        check("midreset_stale", stale, 0);
        release_reset();
        s = {10'd103, 10'd102, 10'd101, 10'd100};
        send_avg(s, 1'b0);
        idle(10);
        commit_and_check("after_reset", 10'd101);

        // Table-driven averages, some with ch3 samples interleaved.
        for (int i = 0; i < 6; i++) begin
            send_avg(vecs[i].s, vecs[i].interleave);
            idle(10);
            commit_and_check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Two averages before a period boundary: last wins, single update.
        s = {10'd200, 10'd200, 10'd200, 10'd200};
        send_avg(s, 1'b0);
        s = {10'd300, 10'd300, 10'd300, 10'd300};
        send_avg(s, 1'b0);
        idle(3);
        u0 = n_updates;
        commit_and_check("overwrite", 10'd300);
        idle(3);
        check("overwrite_single_pulse", n_updates, u0 + 1);

        // period_start with nothing pending.
        drive_cycle(1'b0, 10'd0, 4'd0, 1'b1);
        check("nopend_compare", compare, 300);
        check("nopend_update", update, 0);

        // Average completes on the period_start edge with pend = 0.
        for (int i = 0; i < N_AVG - 1; i++) drive_cycle(1'b1, 10'd600, 4'd0, 1'b0);
        drive_cycle(1'b1, 10'd600, 4'd0, 1'b1);
        check("coinc0_compare", compare, 300);
        check("coinc0_update", update, 0);
        idle(5);
        commit_and_check("coinc0_next", 10'd600);

        // Same coincidence with an older average already pending.
        s = {10'd700, 10'd700, 10'd700, 10'd700};
        send_avg(s, 1'b0);
        for (int i = 0; i < N_AVG - 1; i++) drive_cycle(1'b1, 10'd800, 4'd0, 1'b0);
        drive_cycle(1'b1, 10'd800, 4'd0, 1'b1);
        check("coinc1_compare", compare, 700);
        check("coinc1_update", update, 1);
        idle(5);
        commit_and_check("coinc1_next", 10'd800);

        // Establish compare = 500, then starve the channel.
        s = {10'd500, 10'd500, 10'd500, 10'd500};
        send_avg(s, 1'b0);
        idle(10);
        commit_and_check("hold500", 10'd500);
`ifdef PWM_CMP_WDT_EN
        // 12 cycles elapsed since the last accepted sample.
        idle(WDT_CYCLES - 1 - 12 - 1);
        check("wdt_before_stale", stale, 0);
        idle(1);
        check("wdt_stale", stale, 1);
        check("wdt_compare_held", compare, 500);
        idle(3);
        commit_and_check("wdt_zero", 10'd0);
        check("wdt_still_stale", stale, 1);
        s = {10'd400, 10'd400, 10'd400, 10'd400};
        send_avg(s, 1'b0);
        check("wdt_stale_cleared", stale, 0);
        idle(3);
        commit_and_check("wdt_recover", 10'd400);
`else
        idle(WDT_CYCLES + 100);
        check("nowdt_stale", stale, 0);
        check("nowdt_compare_held", compare, 500);
        drive_cycle(1'b0, 10'd0, 4'd0, 1'b1);
        check("nowdt_no_update", update, 0);
`endif

        idle(3);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_compare_ctrl.md
# pwm_compare_ctrl

Conditions ADC samples from the AVR interface into the PWM compare value. It accepts samples for one channel, box-car averages 2^AVG_LOG2 of them, and holds the result as pending. The result is committed to `compare` only at a PWM period boundary, so the PWM duty never changes mid-period. It sits between the AVR interface (upstream) and the PWM generator (downstream), whose output feeds the phased shift-register delay chain.

## Interface
- `CHANNEL`, 0: ADC channel accepted; all other channels are ignored.
- `AVG_LOG2`, 2: log2 of samples per average, range 0..6.
- `WDT_CYCLES`, 5_000_000: sample-starvation timeout in `clk` cycles (100 ms at 50 MHz).
- `clk` in 1: 50 MHz system clock; one clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `new_sample` in 1: 1-cycle strobe, `sample`/`sample_channel` valid.
- `sample` in 10: unsigned ADC value.
- `sample_channel` in 4: channel of `sample`.
- `period_start` in 1: 1-cycle strobe at PWM counter wrap.
- `compare` out 10: registered PWM compare value.
- `update` out 1: 1-cycle strobe, cycle in which a new `compare` is first visible.
- `stale` out 1: watchdog flag (see Configuration).

## Operation
- Accepted sample: `new_sample && sample_channel == CHANNEL`. All other strobes have no effect on any state.
- Accumulator width is 10+AVG_LOG2, unsigned, and never overflows.
- `cnt` counts accepted samples 0..2^AVG_LOG2-1.
- On the accepted sample where `cnt == 2^AVG_LOG2-1`:
  - avg = (acc + sample) >> AVG_LOG2, truncating.
  - acc ← 0, cnt ← 0, pend_val ← avg, pend ← 1.
- On other accepted samples: acc ← acc + sample, cnt ← cnt+1.
- AVG_LOG2 = 0: every accepted sample becomes pending directly.
- Commit: on an edge where `period_start && pend` (pend as registered before that edge):
  - compare ← pend_val, pend ← 0, update ← 1.
- `period_start` with pend = 0: compare holds and update stays 0.
- Pending overwrite: a new average completing while pend = 1 overwrites pend_val. Last value wins; no error flag.
- Coincidence: an average completing on the same edge as `period_start` is not committed on that edge.
  - If pend was 1 before that edge, the old pend_val commits and the new average becomes pending.
  - If pend was 0, the new average stays pending for the next `period_start`.
- Reset values: compare = 0, update = 0, stale = 0, acc = 0, cnt = 0, pend = 0, pend_val = 0, watchdog counter = 0.
- Reset mid-accumulation discards the partial sum.

## Timing
- Average latency: pend_val is valid 1 cycle after the final accepted sample's strobe.
- Commit latency: `compare`/`update` change at the edge sampling `period_start`, and are visible the cycle after the strobe.
- `update` is high for exactly one cycle per commit.
- Max sample-to-compare latency: one PWM period + 1 cycle after the average completes.
- Back-to-back `new_sample` strobes on consecutive cycles must be handled with no loss.

## Configuration
- `PWM_CMP_WDT_EN` defined:
  - The watchdog counter clears on every accepted sample and increments otherwise, saturating.
  - When it reaches WDT_CYCLES-1: stale ← 1, pend_val ← 0, pend ← 1. `compare` therefore goes to 0 at the next `period_start`, stopping output drive.
  - stale clears when the next average completes.
  - While stale, incomplete accumulation continues normally.
- Not defined: no watchdog logic; `stale` is tied 0; `compare` holds its last value indefinitely.

## Structure
- Shared package `pwm_cmp_pkg`:
  - SAMPLE_W = 10, CHANNEL_W = 4.
  - Default WDT_CYCLES.
  - Watchdog state encoding: WDT_RUN, WDT_STALE.
- Sub-module `boxcar_accum`:
  - Inputs: clk, rst, in_valid, in_data; parameter AVG_LOG2.
  - Outputs: out_valid, a 1-cycle strobe with out_data.
  - Holds acc and cnt.
- The top level holds the channel filter, the pending/commit register, and the watchdog.

## Test plan
- Reset, and reset asserted after 2 of 4 samples → all outputs 0. After release, samples 100,101,102,103 average to 101; partial pre-reset samples are excluded.
- AVG_LOG2 = 2, samples 100,101,102,103 on ch0, then `period_start` 10 cycles later → compare = 101 and update = 1, both the cycle after the strobe.
- Interleave ch3 samples of 1023 between the ch0 samples → ch3 is ignored; compare = 101.
- Two averages (200, then 300) complete before `period_start` → compare = 300, single update pulse.
- Average completes on the same cycle as `period_start` with pend = 0 → compare unchanged that period; committed at the next `period_start`.
- `PWM_CMP_WDT_EN`, WDT_CYCLES = 1000, compare = 500, then no samples → stale = 1 at cycle 999; compare = 0 after the next `period_start`. A new average of 400 clears stale and commits 400.
